water_supply_arbiter: RTL and testbench
=======================================

# water_supply_arbiter

Round-robin arbiter that shares one mains water inlet among `N_MACH` washing-machine controllers. Each controller raises a level request while its FILL, WASH or RINSE stage needs water. The arbiter grants the inlet to one controller at a time and enforces a maximum hold time when others are waiting. It inserts a dead-band between owners so the shared valve fully closes before the next one is served. It sits between the per-machine controllers and the physical inlet valve driver.

## Interface
- `N_MACH`, 4, number of requesting machines (2..8).
- `HOLD_MAX`, 10, maximum consecutive grant cycles while another request is pending (≥2).
- `GUARD`, 2, all-grants-low cycles between two owners (≥1).
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `req`  in  `N_MACH`  level request per machine; held high while water is needed.
- `pause`  in  1  global supply hold (low pressure or service).
- `grant`  out  `N_MACH`  registered, one-hot or zero; the current owner.
- `valve_open`  out  1  registered; drives the mains valve; equals OR of `grant`.
- `expired`  out  `N_MACH`  one-cycle pulse on the owner's bit when it is preempted.
- `busy`  out  1  high in GRANT or GUARD.

## Operation
- States:
  - IDLE: no owner; arbitrate each cycle.
  - GRANT: one owner.
  - GUARD: dead-band countdown.
- Priority pointer `ptr`:
  - Search starts at `ptr` and wraps modulo `N_MACH`.
  - After granting index i, `ptr` = (i+1) mod `N_MACH`.
- IDLE → GRANT: any `req` bit is high and `pause` is low. The winner is the first set bit from `ptr`. `hold_cnt` is cleared to 0.
- GRANT: `hold_cnt` increments each unpaused cycle and saturates at `HOLD_MAX`.
  - Owner drops `req` → GUARD; no `expired` pulse.
  - `hold_cnt` reaches `HOLD_MAX` while any other `req` bit is high → preempt. Go to GUARD and pulse `expired[owner]`.
  - `hold_cnt` at `HOLD_MAX` with no competitor → owner keeps the grant indefinitely. A competitor arriving later preempts on the next cycle.
- GUARD: `guard_cnt` loads `GUARD`, decrements each unpaused cycle, and at 0 goes to IDLE. `req` changes during GUARD are ignored.
- `pause` high:
  - `grant` and `valve_open` are forced to 0.
  - State, owner, `ptr`, `hold_cnt` and `guard_cnt` are frozen.
  - `expired` stays 0.
- `pause` falls:
  - Owner still requesting → its grant is restored and it continues with the remaining hold time.
  - Owner dropped `req` during the pause → treated as a release; go to GUARD.
- A preempted machine keeps `req` high and is re-served in round-robin order.
- Reset (at any time, including mid-grant or mid-pause) on the next edge:
  - State IDLE, `ptr`=0, counters 0.
  - `grant`=0, `valve_open`=0, `expired`=0, `busy`=0.

## Timing
- `req` sampled at edge t → `grant` and `valve_open` high after edge t+1 (1-cycle latency).
- Release at edge t → `grant` low after t+1. Next owner is granted after t+1+`GUARD`+1 at the earliest (the IDLE arbitration cycle).
- A preempted owner holds the grant for exactly `HOLD_MAX` cycles. `expired` is high in the first cycle `grant` is low.
- `pause` takes effect one edge after it is sampled, in both directions.
- `hold_cnt` width is clog2(`HOLD_MAX`+1). `guard_cnt` width is clog2(`GUARD`+1). `ptr` width is clog2(`N_MACH`).

## Structure
- Shared package `awmc_pkg`:
  - Arbiter state enum (IDLE, GRANT, GUARD).
  - Machine stage codes shared with the controllers.
  - Default constants `HOLD_MAX`=10 and `GUARD`=2.
- One sub-module `rr_pick`: combinational; inputs `req` and `ptr`; outputs the winner index and a valid flag. The top level holds the FSM and counters.

## Test plan
All scenarios use `N_MACH`=4, `HOLD_MAX`=10, `GUARD`=2.
- Reset: hold `reset` low for 2 cycles with `req`=1111 → `grant`=0000, `valve_open`=0, `busy`=0. After release, `grant`=0001 one edge later.
- Lone requester: `req`=0001 for 30 cycles → `grant`=0001 from cycle 1 for all 30 cycles; `expired` never pulses. Drop `req` → 2 GUARD cycles, then IDLE.
- Contention: `req`=0101 from IDLE with `ptr`=0 → `grant`=0001 for 10 cycles, then `expired`=0001 for one cycle, 2 cycles of 0000, then `grant`=0100.
- Full rotation: `req`=1111 held → grants in order 0001, 0010, 0100, 1000, 0001. Each lasts 10 cycles, separated by 2 zero cycles plus 1 IDLE cycle.
- Pause: `pause` high for 5 cycles after 4 grant cycles → `grant`=0 and `valve_open`=0 throughout the pause. Grant restored one edge after `pause` falls, then held 6 more cycles before preemption.
- Reset mid-grant: `reset` low at grant cycle 3 → all outputs 0 on the next edge. After release, `req`=0110 → `grant`=0010 (`ptr` is back at 0).

Source files
------------

// File: rtl/awmc_pkg.sv
// Shared definitions for the washing-machine water supply: arbiter states,
// machine stage codes and default arbiter timing constants.
package awmc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GUARD = 2'd2
    } arb_state_e;

    typedef enum logic [2:0] {
        STAGE_OFF   = 3'd0,
        STAGE_FILL  = 3'd1,
        STAGE_WASH  = 3'd2,
        STAGE_RINSE = 3'd3,
        STAGE_SPIN  = 3'd4,
        STAGE_DRAIN = 3'd5
    } stage_e;

    localparam int HOLD_MAX_DEF = 10;
    localparam int GUARD_DEF    = 2;

    // Controllers raise their inlet request only in the stages that draw water.
    function automatic logic stage_needs_water(input stage_e stage);
        return (stage == STAGE_FILL) || (stage == STAGE_WASH) || (stage == STAGE_RINSE);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo N_MACH.
module rr_pick #(
    parameter  int N_MACH = 4,
    localparam int PW     = $clog2(N_MACH)
) (
    input  logic [N_MACH-1:0] req,
    input  logic [PW-1:0]     ptr,
    output logic [PW-1:0]     winner,
    output logic              valid
);

    localparam logic [PW:0] N_W = (PW+1)'(N_MACH);

    logic [PW:0] idx;

    // NOTE: every output and temporary gets a default before the loop so no latch is inferred.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        idx    = '0;
        // Scan from the far end so the candidate closest to ptr is written last and wins.
        for (int k = N_MACH - 1; k >= 0; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= N_W) begin
                idx = idx - N_W;
            end
            if (req[idx[PW-1:0]]) begin
                valid  = 1'b1;
                winner = idx[PW-1:0];
            end
        end
    end

endmodule

// File: rtl/water_supply_arbiter.sv
// Round-robin owner of the shared mains inlet with a hold-time limit under
// contention, a valve-closing dead-band between owners and a global pause.
module water_supply_arbiter
    import awmc_pkg::*;
#(
    parameter int N_MACH   = 4,
    parameter int HOLD_MAX = HOLD_MAX_DEF,
    parameter int GUARD    = GUARD_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_MACH-1:0] req,
    input  logic              pause,
    output logic [N_MACH-1:0] grant,
    output logic              valve_open,
    output logic [N_MACH-1:0] expired,
    output logic              busy
);

    localparam int PW = $clog2(N_MACH);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam int GW = $clog2(GUARD + 1);

    localparam logic [PW-1:0] LAST_IDX   = PW'(N_MACH - 1);
    localparam logic [HW-1:0] HOLD_MAX_W = HW'(HOLD_MAX);
    localparam logic [GW-1:0] GUARD_W    = GW'(GUARD);

    arb_state_e        state;
    logic [PW-1:0]     owner;
    logic [PW-1:0]     ptr;
    logic [HW-1:0]     hold_cnt;
    logic [GW-1:0]     guard_cnt;

    logic [PW-1:0]     pick_idx;
    logic              pick_valid;
    logic [N_MACH-1:0] owner_oh;
    logic [N_MACH-1:0] pick_oh;
    logic [HW-1:0]     hold_inc;
    logic              rival;

    rr_pick #(.N_MACH(N_MACH)) u_pick (
        .req    (req),
        .ptr    (ptr),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        owner_oh = N_MACH'(1) << owner;
        pick_oh  = N_MACH'(1) << pick_idx;
        hold_inc = (hold_cnt == HOLD_MAX_W) ? hold_cnt : hold_cnt + HW'(1);
        rival    = |(req & ~owner_oh);
    end

    // NOTE: all state uses non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            owner      <= '0;
            ptr        <= '0;
            hold_cnt   <= '0;
            guard_cnt  <= '0;
            grant      <= '0;
            valve_open <= 1'b0;
            expired    <= '0;
        end else if (pause) begin
            // Valve shut, everything else frozen until the supply returns.
            grant      <= '0;
            valve_open <= 1'b0;
            expired    <= '0;
        end else begin
            grant      <= '0;
            valve_open <= 1'b0;
            expired    <= '0;
            case (state)
                ARB_IDLE: begin
                    if (pick_valid) begin
                        state      <= ARB_GRANT;
                        owner      <= pick_idx;
                        ptr        <= (pick_idx == LAST_IDX) ? '0 : pick_idx + PW'(1);
                        hold_cnt   <= '0;
                        grant      <= pick_oh;
                        valve_open <= 1'b1;
                    end
                end
                ARB_GRANT: begin
                    if (!req[owner]) begin
                        state     <= ARB_GUARD;
                        guard_cnt <= GUARD_W;
                    end else if (hold_inc == HOLD_MAX_W && rival) begin
                        state     <= ARB_GUARD;
                        guard_cnt <= GUARD_W;
                        expired   <= owner_oh;
                    end else begin
                        hold_cnt   <= hold_inc;
                        grant      <= owner_oh;
                        valve_open <= 1'b1;
                    end
                end
                ARB_GUARD: begin
                    if (guard_cnt <= GW'(1)) begin
                        state     <= ARB_IDLE;
                        guard_cnt <= '0;
                    end else begin
                        guard_cnt <= guard_cnt - GW'(1);
                    end
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

    assign busy = (state != ARB_IDLE);

endmodule

// File: tb/tb_water_supply_arbiter.sv
// Directed and randomized bench for water_supply_arbiter (N_MACH=4, HOLD_MAX=10,
// GUARD=2) against a cycle-level behavioural model of the inlet sharing rules.
module tb_water_supply_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 10;
    localparam int GRD  = 2;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic         pause;
    logic [N-1:0] grant;
    logic         valve_open;
    logic [N-1:0] expired;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: who owns the inlet, how many grant cycles are used,
    // how many dead cycles remain, and where the next search begins.
    int           m_phase;   // 0 free, 1 owned, 2 dead-band
    int           m_owner;
    int           m_next;
    int           m_used;
    int           m_dead;
    logic [N-1:0] m_grant;
    logic [N-1:0] m_exp;

    water_supply_arbiter #(.N_MACH(N), .HOLD_MAX(HOLD), .GUARD(GRD)) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .pause      (pause),
        .grant      (grant),
        .valve_open (valve_open),
        .expired    (expired),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst, input logic [N-1:0] r, input logic p);
        logic found;
        int   i;
        if (!rst) begin
            m_phase = 0; m_next = 0; m_used = 0; m_dead = 0; m_owner = 0;
            m_grant = '0; m_exp = '0;
            return;
        end
        m_grant = '0;
        m_exp   = '0;
        if (p) return;
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    i = (m_next + k) % N;
                    if (!found && r[i]) begin
                        found   = 1'b1;
                        m_owner = i;
                        m_next  = (i + 1) % N;
                        m_used  = 0;
                        m_phase = 1;
                        m_grant = N'(1) << i;
                    end
                end
            end
            1: begin
                if (!r[m_owner]) begin
                    m_phase = 2; m_dead = GRD;
                end else if ((r & ~(N'(1) << m_owner)) != 0 && m_used + 1 >= HOLD) begin
                    m_phase = 2; m_dead = GRD;
                    m_exp   = N'(1) << m_owner;
                end else begin
                    m_used  = (m_used + 1 > HOLD) ? HOLD : m_used + 1;
                    m_grant = N'(1) << m_owner;
                end
            end
            default: begin
                m_dead--;
                if (m_dead == 0) m_phase = 0;
            end
        endcase
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic cyc(input logic rst, input logic [N-1:0] r, input logic p);
        reset = rst;
        req   = r;
        pause = p;
        @(posedge clk);
        model_edge(rst, r, p);
        #1;
        check("grant", grant, m_grant);
        check("valve_open", valve_open, (m_grant != 0));
        check("expired", expired, m_exp);
        check("busy", busy, (m_phase != 0));
    endtask

    initial begin
        logic [N-1:0] r_cur;
        logic         rst_r;
        logic         p_r;

        reset = 1'b0; req = '0; pause = 1'b0;

        // Reset held with all requests high, then first grant one edge after release.
        cyc(1'b0, 4'b1111, 1'b0);
        cyc(1'b0, 4'b1111, 1'b0);
        check("rst_grant", grant, 4'b0000);
        check("rst_valve", valve_open, 1'b0);
        check("rst_busy", busy, 1'b0);
        cyc(1'b1, 4'b1111, 1'b0);
        check("first_grant", grant, 4'b0001);
        repeat (4) cyc(1'b1, 4'b0000, 1'b0);

        // Lone requester keeps the inlet indefinitely, then releases through the dead-band.
        for (int k = 0; k < 30; k++) begin
            cyc(1'b1, 4'b0001, 1'b0);
            check("lone_grant", grant, 4'b0001);
            check("lone_expired", expired, 4'b0000);
        end
        cyc(1'b1, 4'b0000, 1'b0);
        check("lone_rel_busy0", busy, 1'b1);
        check("lone_rel_grant", grant, 4'b0000);
        cyc(1'b1, 4'b0000, 1'b0);
        check("lone_rel_busy1", busy, 1'b1);
        cyc(1'b1, 4'b0000, 1'b0);
        check("lone_rel_idle", busy, 1'b0);

        // Contention from a fresh pointer.
        cyc(1'b0, 4'b0000, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            cyc(1'b1, 4'b0101, 1'b0);
            check("cont_grant", grant, (k <= 10) ? 4'b0001 : (k <= 13) ? 4'b0000 : 4'b0100);
            check("cont_expired", expired, (k == 11) ? 4'b0001 : 4'b0000);
        end
        repeat (4) cyc(1'b1, 4'b0000, 1'b0);

        // Full rotation: 10 grant cycles then 3 empty cycles per owner.
        cyc(1'b0, 4'b0000, 1'b0);
        for (int k = 0; k < 62; k++) begin
            logic [N-1:0] own;
            own = N'(1) << ((k / 13) % N);
            cyc(1'b1, 4'b1111, 1'b0);
            check("rot_grant", grant, ((k % 13) < 10) ? own : 4'b0000);
            check("rot_expired", expired, ((k % 13) == 10) ? own : 4'b0000);
        end
        repeat (4) cyc(1'b1, 4'b0000, 1'b0);

        // Pause mid-grant: valve shut, remaining hold time kept.
        cyc(1'b0, 4'b0000, 1'b0);
        repeat (4) begin
            cyc(1'b1, 4'b0101, 1'b0);
            check("pz_pre", grant, 4'b0001);
        end
        repeat (5) begin
            cyc(1'b1, 4'b0101, 1'b1);
            check("pz_grant", grant, 4'b0000);
            check("pz_valve", valve_open, 1'b0);
            check("pz_busy", busy, 1'b1);
        end
        repeat (6) begin
            cyc(1'b1, 4'b0101, 1'b0);
            check("pz_post", grant, 4'b0001);
        end
        cyc(1'b1, 4'b0101, 1'b0);
        check("pz_preempt_grant", grant, 4'b0000);
        check("pz_preempt_exp", expired, 4'b0001);
        repeat (6) cyc(1'b1, 4'b0000, 1'b0);

        // Owner drops its request while paused: treated as a release.
        cyc(1'b0, 4'b0000, 1'b0);
        repeat (2) cyc(1'b1, 4'b0001, 1'b0);
        repeat (3) cyc(1'b1, 4'b0000, 1'b1);
        cyc(1'b1, 4'b0000, 1'b0);
        check("pzrel_grant", grant, 4'b0000);
        check("pzrel_busy", busy, 1'b1);
        check("pzrel_expired", expired, 4'b0000);
        repeat (3) cyc(1'b1, 4'b0000, 1'b0);

        // Reset in the middle of a grant.
        cyc(1'b0, 4'b0000, 1'b0);
        repeat (3) cyc(1'b1, 4'b0001, 1'b0);
        cyc(1'b0, 4'b0001, 1'b0);
        check("mid_rst_grant", grant, 4'b0000);
        check("mid_rst_valve", valve_open, 1'b0);
        check("mid_rst_exp", expired, 4'b0000);
        check("mid_rst_busy", busy, 1'b0);
        cyc(1'b1, 4'b0110, 1'b0);
        check("mid_rst_regrant", grant, 4'b0010);

        // Randomized traffic with occasional pauses and resets.
        r_cur = '0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3) == 0) r_cur = N'($urandom);
            rst_r = ($urandom_range(79) != 0);
            p_r   = ($urandom_range(9) == 0);
            cyc(rst_r, r_cur, p_r);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
